// File: rtl/cordic_ui_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : cordic_ui_pkg                                             |
// | Purpose  : Shared definitions for the CORDIC session controller:     |
// |            FSM state encoding, ASCII command bytes, print_line bit   |
// |            positions and a small sizing helper.                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package cordic_ui_pkg;

  typedef enum logic [3:0] {
    ST_WELCOME   = 4'd0,
    ST_ASK       = 4'd1,
    ST_WAIT_CMD  = 4'd2,
    ST_ENTRY     = 4'd3,
    ST_SETTLE    = 4'd4,
    ST_CALC      = 4'd5,
    ST_RESULT    = 4'd6,
    ST_EXIT_WAIT = 4'd7,
    ST_HALT      = 4'd8
  } state_t;

  // ASCII command bytes: '0'+k selects source k, 'C' continues, 'E' exits
  localparam logic [7:0] c_cmd_src_base = 8'h30;
  localparam logic [7:0] c_cmd_clear    = 8'h43;
  localparam logic [7:0] c_cmd_exit     = 8'h45;

  // print_line bit positions
  localparam int c_pl_w      = 6;
  localparam int c_pl_ask    = 0;
  localparam int c_pl_err    = 1;
  localparam int c_pl_enter  = 2;
  localparam int c_pl_tag    = 3;
  localparam int c_pl_result = 4;
  localparam int c_pl_exit   = 5;

  // Largest of three limits, floored at 2 so derived widths are never zero
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = 2;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : delay_counter                                             |
// | Purpose  : Loadable down-counter with terminal-count flag. Shared by |
// |            the welcome hold, settle delay and entry timeout.         |
// | Ports    : clk, reset (async, active-high)                           |
// |            load      - load load_val this cycle (wins over count)    |
// |            load_val  - value to count down from                      |
// |            tc        - high while the count is zero                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero so the count never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/cordic_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cordic_session_ctrl                                       |
// | Purpose  : User-session sequencer around a CORDIC handler: welcome   |
// |            screen, command prompt, source selection, angle capture   |
// |            with range check/timeout, settle delay, start/busy, and   |
// |            continue/exit prompt. All outputs are registered.         |
// | Ports    : clk, reset (async, active-high)                           |
// |            cmd_valid/cmd_code   - ASCII command strobe and byte      |
// |            src_en/src_valid/src_angle - per-source enable & data     |
// |            cordic_start/cordic_angle/cordic_done/busy - CORDIC i/f   |
// |            welcome/print_line/disp_src - VGA controls                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cordic_session_ctrl
  import cordic_ui_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int ANGLE_W     = 9,
  parameter int WELCOME_CYC = 100000000,
  parameter int SETTLE_CYC  = 50,
  parameter int SRC_TIMEOUT = 0,
  parameter int ANGLE_MAX   = 359
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  input  logic [7:0]                 cmd_code,
  output logic [NUM_SRC-1:0]         src_en,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*ANGLE_W-1:0] src_angle,
  output logic                       cordic_start,
  output logic [ANGLE_W-1:0]         cordic_angle,
  input  logic                       cordic_done,
  output logic                       welcome,
  output logic [5:0]                 print_line,
  output logic [2:0]                 disp_src,
  output logic                       busy
);

  localparam int c_cnt_w = $clog2(max3(WELCOME_CYC, SETTLE_CYC, SRC_TIMEOUT));
  localparam bit c_timeout_en = (SRC_TIMEOUT > 0);

  // Counts run from limit-1 down to 0, so terminal count lands exactly limit clocks after load
  localparam logic [c_cnt_w-1:0] c_ld_welcome = c_cnt_w'(WELCOME_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_ld_settle  = c_cnt_w'(SETTLE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_ld_timeout = c_cnt_w'(c_timeout_en ? SRC_TIMEOUT - 1 : 0);
  localparam logic [ANGLE_W-1:0] c_angle_max  = ANGLE_W'(ANGLE_MAX);

  state_t               state_q, state_d;
  logic                 welcome_q, welcome_d;
  logic [c_pl_w-1:0]    print_line_q, print_line_d;
  logic [NUM_SRC-1:0]   src_en_q, src_en_d;
  logic [2:0]           disp_src_q, disp_src_d;
  logic                 cordic_start_q, cordic_start_d;
  logic                 busy_q, busy_d;
  logic [ANGLE_W-1:0]   cordic_angle_q, cordic_angle_d;

  logic                 w_cnt_load;
  logic [c_cnt_w-1:0]   w_cnt_val;
  logic                 w_cnt_tc;

  logic                 w_sel_valid;
  logic [ANGLE_W-1:0]   w_sel_angle;
  logic                 w_cmd_legal;
  logic [2:0]           w_cmd_idx;
  logic [NUM_SRC-1:0]   w_cmd_onehot;
  logic                 w_angle_bad;

  delay_counter #(
    .CNT_W (c_cnt_w)
  ) u_delay_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .tc       (w_cnt_tc)
  );

  // Source mux keyed by the latched selection, and command-byte decode
  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_angle  = '0;
    w_cmd_legal  = 1'b0;
    w_cmd_idx    = '0;
    w_cmd_onehot = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (disp_src_q == 3'(k)) begin
        w_sel_valid = src_valid[k];
        w_sel_angle = src_angle[k*ANGLE_W +: ANGLE_W];
      end
      if (cmd_code == (c_cmd_src_base + 8'(k))) begin
        w_cmd_legal     = 1'b1;
        w_cmd_idx       = 3'(k);
        w_cmd_onehot[k] = 1'b1;
      end
    end
  end

  assign w_angle_bad = (w_sel_angle > c_angle_max);

  // State register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_WELCOME;
      welcome_q      <= 1'b0;
      print_line_q   <= '0;
      src_en_q       <= '0;
      disp_src_q     <= '0;
      cordic_start_q <= 1'b0;
      busy_q         <= 1'b0;
      cordic_angle_q <= '0;
    end else begin
      state_q        <= state_d;
      welcome_q      <= welcome_d;
      print_line_q   <= print_line_d;
      src_en_q       <= src_en_d;
      disp_src_q     <= disp_src_d;
      cordic_start_q <= cordic_start_d;
      busy_q         <= busy_d;
      cordic_angle_q <= cordic_angle_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WELCOME:   if (welcome_q && w_cnt_tc) state_d = ST_ASK;
      ST_ASK:       state_d = ST_WAIT_CMD;
      ST_WAIT_CMD:  if (cmd_valid && w_cmd_legal) state_d = ST_ENTRY;
      ST_ENTRY: begin
        // A valid entry on the timeout cycle still counts as entered
        if (w_sel_valid) begin
          state_d = w_angle_bad ? ST_ASK : ST_SETTLE;
        end else if (c_timeout_en && w_cnt_tc) begin
          state_d = ST_ASK;
        end
      end
      ST_SETTLE:    if (w_cnt_tc) state_d = ST_CALC;
      ST_CALC:      if (cordic_done) state_d = ST_RESULT;
      ST_RESULT:    state_d = ST_EXIT_WAIT;
      ST_EXIT_WAIT: begin
        if (cmd_valid && cmd_code == c_cmd_clear) begin
          state_d = ST_ASK;
        end else if (cmd_valid && cmd_code == c_cmd_exit) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_WELCOME;
    endcase
  end

  // Output and counter-control logic
  always_comb begin
    welcome_d      = welcome_q;
    print_line_d   = print_line_q;
    src_en_d       = src_en_q;
    disp_src_d     = disp_src_q;
    cordic_start_d = 1'b0;
    busy_d         = busy_q;
    cordic_angle_d = cordic_angle_q;
    w_cnt_load     = 1'b0;
    w_cnt_val      = '0;
    case (state_q)
      ST_WELCOME: begin
        // welcome_q low marks the first cycle after reset: start the hold
        if (!welcome_q) begin
          welcome_d  = 1'b1;
          w_cnt_load = 1'b1;
          w_cnt_val  = c_ld_welcome;
        end else if (w_cnt_tc) begin
          welcome_d  = 1'b0;
        end
      end
      ST_ASK: begin
        print_line_d[c_pl_ask] = 1'b1;
      end
      ST_WAIT_CMD: begin
        if (cmd_valid) begin
          if (w_cmd_legal) begin
            src_en_d                 = w_cmd_onehot;
            disp_src_d               = w_cmd_idx;
            print_line_d[c_pl_enter] = 1'b1;
            print_line_d[c_pl_tag]   = 1'b1;
            print_line_d[c_pl_err]   = 1'b0;
            w_cnt_load               = 1'b1;
            w_cnt_val                = c_ld_timeout;
          end else begin
            print_line_d[c_pl_err]   = 1'b1;
          end
        end
      end
      ST_ENTRY: begin
        if ((w_sel_valid && w_angle_bad) ||
            (!w_sel_valid && c_timeout_en && w_cnt_tc)) begin
          print_line_d[c_pl_err]   = 1'b1;
          print_line_d[c_pl_enter] = 1'b0;
          print_line_d[c_pl_tag]   = 1'b0;
          src_en_d                 = '0;
        end else if (w_sel_valid) begin
          cordic_angle_d = w_sel_angle;
          src_en_d       = '0;
          w_cnt_load     = 1'b1;
          w_cnt_val      = c_ld_settle;
        end
      end
      ST_SETTLE: begin
        if (w_cnt_tc) begin
          cordic_start_d = 1'b1;
          busy_d         = 1'b1;
        end
      end
      ST_CALC: begin
        if (cordic_done) busy_d = 1'b0;
      end
      ST_RESULT: begin
        print_line_d[c_pl_result] = 1'b1;
        print_line_d[c_pl_exit]   = 1'b1;
      end
      ST_EXIT_WAIT: begin
        if (cmd_valid && (cmd_code == c_cmd_clear || cmd_code == c_cmd_exit)) begin
          print_line_d = '0;
        end
      end
      ST_HALT: begin
        welcome_d    = 1'b0;
        print_line_d = '0;
        src_en_d     = '0;
        busy_d       = 1'b0;
      end
      default: begin
        welcome_d = 1'b0;
      end
    endcase
  end

  assign src_en       = src_en_q;
  assign cordic_start = cordic_start_q;
  assign cordic_angle = cordic_angle_q;
  assign welcome      = welcome_q;
  assign print_line   = print_line_q;
  assign disp_src     = disp_src_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: doc/cordic_session_ctrl.md
CORDIC_SESSION_CTRL -- requirements
Module: cordic_session_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, number of angle-entry sources (range 1..8).
REQ-002 SHALL have parameter ANGLE_W, default 9, angle width in whole degrees.
REQ-003 SHALL have parameter WELCOME_CYC, default 100000000, welcome-screen hold in clocks.
REQ-004 SHALL have parameter SETTLE_CYC, default 50, settle delay before CORDIC start (>=1).
REQ-005 SHALL have parameter SRC_TIMEOUT, default 0, entry timeout in clocks; 0 disables timeout.
REQ-006 SHALL have parameter ANGLE_MAX, default 359, largest legal angle.
REQ-007 SHALL have port clk, input, 1, sole clock; reset is asynchronous and active-high.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port cmd_valid, input, 1, one-cycle strobe qualifying cmd_code.
REQ-010 SHALL have port cmd_code, input, 8, ASCII command byte.
REQ-011 SHALL have port src_en, output, NUM_SRC, one-hot enable of the selected source.
REQ-012 SHALL have port src_valid, input, NUM_SRC, per-source one-cycle "value entered" strobe.
REQ-013 SHALL have port src_angle, input, NUM_SRC*ANGLE_W, packed source angles, source k at [k*ANGLE_W +: ANGLE_W].
REQ-014 SHALL have port cordic_start, output, 1, one-cycle start pulse.
REQ-015 SHALL have port cordic_angle, output, ANGLE_W, registered angle for the CORDIC handler.
REQ-016 SHALL have port cordic_done, input, 1, one-cycle completion strobe from the CORDIC handler.
REQ-017 SHALL have port welcome, output, 1, welcome-screen enable to VGA.
REQ-018 SHALL have port print_line, output, 6, VGA line enables: [0] ask, [1] error, [2] enter value, [3] source tag, [4] result, [5] exit prompt.
REQ-019 SHALL have port disp_src, output, 3, index of the source whose live data the VGA shows.
REQ-020 SHALL have port busy, output, 1, high from cordic_start until cordic_done.

Function
REQ-021 SHALL implement states WELCOME, ASK, WAIT_CMD, ENTRY, SETTLE, CALC, RESULT, EXIT_WAIT, HALT.
REQ-022 WELCOME: welcome=1; after exactly WELCOME_CYC clocks clear welcome, go to ASK.
REQ-023 ASK: set print_line[0]; go to WAIT_CMD next cycle.
REQ-024 WAIT_CMD: cmd_valid with cmd_code = 8'h30+k and k<NUM_SRC selects source k: src_en[k]=1, disp_src=k, print_line[2]=print_line[3]=1, go to ENTRY.
REQ-025 WAIT_CMD: any other valid code sets print_line[1] and stays; a later legal code clears print_line[1].
REQ-026 ENTRY: only src_valid of the selected source is honoured; others ignored; captured angle is latched into cordic_angle on that cycle.
REQ-027 ENTRY: captured angle > ANGLE_MAX sets print_line[1], clears src_en, returns to ASK; cordic_angle keeps its previous value.
REQ-028 ENTRY: if SRC_TIMEOUT>0 and no valid entry within SRC_TIMEOUT clocks, set print_line[1], clear src_en, return to ASK.
REQ-029 SETTLE: wait SETTLE_CYC clocks after capture, then pulse cordic_start for one cycle, enter CALC.
REQ-030 CALC: busy=1 until cordic_done; cordic_done outside CALC SHALL be ignored.
REQ-031 RESULT: set print_line[4] and print_line[5], go to EXIT_WAIT.
REQ-032 EXIT_WAIT: 'C' (8'h43) clears print_line to 0 and goes to ASK; 'E' (8'h45) clears print_line and goes to HALT; other codes ignored.
REQ-033 HALT: all outputs idle; leaves only on reset.
REQ-034 cmd_valid and src_valid in the same cycle: state-appropriate input wins, other dropped.
REQ-035 All counters SHALL be sized by $clog2 of their limit and never wrap.

Reset
REQ-036 On reset assertion (any time, including mid-CALC): state=WELCOME, counters=0, print_line=0, src_en=0, cordic_start=0, busy=0, cordic_angle=0, disp_src=0, welcome=0 (rises first cycle after release).

Structure
REQ-037 State encoding, ASCII command constants and print_line bit indices SHALL live in the shared package cordic_ui_pkg.
REQ-038 A single sub-module delay_counter (load/terminal-count) SHALL serve WELCOME, SETTLE and timeout.

Verification
REQ-039 WELCOME_CYC=10: release reset -> welcome high exactly 10 clocks, then print_line=6'b000001.
REQ-040 cmd '1' (8'h31), src_valid[1] with angle 45 -> cordic_angle=45, cordic_start pulses SETTLE_CYC cycles later, busy high until cordic_done.
REQ-041 cmd 8'h39 with NUM_SRC=2 -> print_line[1]=1, remains WAIT_CMD; then '0' clears error.
REQ-042 source angle 400 -> print_line[1]=1, return to ASK, no cordic_start.
REQ-043 SRC_TIMEOUT=20, no entry -> src_en=0 and ASK after 20 clocks.
REQ-044 reset asserted during CALC -> all outputs at reset values asynchronously; later cordic_done ignored.
